aes_key_expand: RTL
===================

# aes_key_expand

Sequential AES key-expansion engine supporting AES-128, AES-192 and AES-256, selected per key at run time. It accepts a cipher key over a valid/ready handshake and streams the Nr+1 128-bit round keys in order over a second valid/ready handshake, one 32-bit expanded word per cycle. It sits between the key register file and the iterative encryption datapath. It generalises the single-step 128-bit combinational schedule step to all key lengths, with backpressure.

## Interface
- MAX_KEY_W, default 256: largest key length supported (128, 192 or 256). Modes above it are rejected.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid_i  in  1  key offer.
- key_ready_o  out  1  engine idle and able to accept a key.
- key_i  in  256  cipher key.
  - Byte n sits at [8n+7:8n], so word w_j is key_i[32j+31:32j].
  - Bits above the selected length are ignored.
- key_len_i  in  2  mode: 0=128, 1=192, 2=256, 3=reserved.
- rk_valid_o  out  1  round key present on rk_o.
- rk_ready_i  in  1  consumer accepts rk_o.
- rk_o  out  128  round key {w_4r+3, w_4r+2, w_4r+1, w_4r}, with w_4r at [31:0].
- rk_idx_o  out  4  round index r, 0..Nr.
- rk_last_o  out  1  high with rk_valid_o when r = Nr.
- err_o  out  1  one-cycle pulse when an illegal mode is accepted.

## Operation
- Mode constants:
  - Nk = 4/6/8 and Nr = 10/12/14.
  - Total words W = 4(Nr+1) = 44/52/60.
- States:
  - IDLE: key_ready_o=1. When key_valid_i and key_ready_o are both high, the engine latches key_i, Nk and Nr, clears the word counter i, sets rcon=0x01 and goes to RUN.
  - RUN: produces word w_i each unstalled cycle.
  - DONE: waits for the last round key to be consumed, then returns to IDLE.
- Illegal mode: key_len_i=3, or a mode wider than MAX_KEY_W.
  - The handshake still completes.
  - err_o pulses on the following cycle and the state stays IDLE.
  - No rk is produced.
- Word generation:
  - For i<Nk, w_i is taken from the latched key.
  - Otherwise w_i = w_{i-Nk} ^ f(w_{i-1}).
  - When i mod Nk = 0, f = SubWord(RotWord(x)) with rcon XORed into byte 0 ([7:0]).
    - RotWord: byte0←byte1, byte1←byte2, byte2←byte3, byte3←byte0.
  - When Nk=8 and i mod 8 = 4, f = SubWord(x).
  - In all other cases, f = x.
- rcon update: after each use, rcon←{rcon[6:0],0}, or 0x1b if rcon[7] was set. The last rcon used is 0x36 for 128, 0x80 for 192 and 0x40 for 256.
- Window: an 8-word shift register holds the last Nk words, so w_{i-Nk} is a mode-indexed tap.
- Collector and output:
  - A 4-word collector assembles each round key.
  - When the 4th word is captured, it moves to the output register if that register is empty or is being consumed on the same edge.
  - If neither holds, generation stalls: i, the window, rcon and the collector all hold.
- Output stability: rk_o, rk_idx_o and rk_last_o stay stable while rk_valid_o=1 and rk_ready_i=0.
- key_valid_i is ignored outside IDLE.

## Timing
- Reset values: key_ready_o=1, rk_valid_o=0, rk_o=0, rk_idx_o=0, rk_last_o=0, err_o=0, state IDLE.
- Reset applies mid-operation as well and discards all progress.
- Let E0 be the accept edge:
  - Words w_0..w_3 are captured at E1..E4.
  - rk_valid_o rises after E4 (4-cycle latency to rk0).
- With rk_ready_i held at 1, one round key is produced every 4 cycles.
- The final round key is valid after edge E_W (44/52/60).
- key_ready_o returns high the cycle after the edge on which rk_last is accepted.
- Consumer stall:
  - Generation continues until the collector is full and the output register is still held.
  - Sustained throughput returns to 1 round key per 4 cycles, with no bubble introduced by the stall.
- Simultaneous accept of rk_last and a new key_valid_i: the new key is not accepted until the next cycle.

## Structure
- Package aes_key_pkg holds:
  - key length encodings;
  - Nk, Nr and W per mode;
  - RCON_INIT=0x01 and RCON_RED=0x1b;
  - the state enum.
- Sub-module aes_key_word_fn:
  - Combinational; inputs are a word, rcon and the rot/rcon and sub-only selects.
  - Computes RotWord, SubWord and the rcon XOR, using four existing aes_sbox instances.
  - Also outputs the next rcon value.
- Top level holds the FSM, counter, window, collector and output register.

## Test plan
- AES-128, key bytes 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1:
  - rk0 equals the key.
  - rk10 bytes are d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last_o=1 and rk_idx_o=10.
  - Last round key valid 44 cycles after accept.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: rk12 bytes e98ba06f448c773c8ecc720401002202, 13 keys total.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: rk14 bytes fe4890d1e6188d0b046df344706c631e, 15 keys total.
- Random rk_ready_i stalls on the AES-192 vector:
  - Identical rk sequence to the unstalled run.
  - rk_o is stable whenever valid is high and ready is low.
  - No round key is lost or duplicated.
- key_len_i=3, and key_len_i=2 with MAX_KEY_W=128: err_o pulses once, rk_valid_o stays 0, key_ready_o stays 1.
- Reset asserted mid-RUN (after rk3) and then a new AES-128 key: outputs reset to their reset values, then the full correct sequence for the new key with no residue from the first.

Source files
------------

// File: rtl/aes_key_pkg.sv
// aes_key_pkg: mode encodings, per-mode schedule constants and FSM states for the key expander
package aes_key_pkg;
  localparam logic [1:0] LEN_128 = 2'd0;
  localparam logic [1:0] LEN_192 = 2'd1;
  localparam logic [1:0] LEN_256 = 2'd2;
  localparam logic [1:0] LEN_RSV = 2'd3;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_RED = 8'h1b;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [3:0] nk_of(input logic [1:0] len);
    return len == LEN_256 ? 4'd8 : len == LEN_192 ? 4'd6 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(input logic [1:0] len);
    return len == LEN_256 ? 4'd14 : len == LEN_192 ? 4'd12 : 4'd10;
  endfunction
  function automatic logic [5:0] words_of(input logic [1:0] len);
    return len == LEN_256 ? 6'd60 : len == LEN_192 ? 6'd52 : 6'd44;
  endfunction
  function automatic int key_bits_of(input logic [1:0] len);
    return 128 + 64 * int'(len);
  endfunction
endpackage

// File: rtl/aes_key_word_fn.sv
// aes_key_word_fn: schedule word transform (RotWord/SubWord/rcon) and next-rcon computation
module aes_key_word_fn
  import aes_key_pkg::*;
(
  input  logic [31:0] word,
  input  logic [7:0]  rcon,
  input  logic        rot,
  input  logic        sub,
  output logic [31:0] f,
  output logic [7:0]  rcon_next
);
  logic [31:0] x, s;
  assign x = rot ? {word[7:0], word[31:8]} : word;
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(x[8*b+:8]), .s(s[8*b+:8]));
  end
  assign f = rot ? s ^ {24'h0, rcon} : sub ? s : word;
  assign rcon_next = rcon[7] ? RCON_RED : {rcon[6:0], 1'b0};
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box computed as GF(2^8) inverse followed by the affine map
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] q, r;
    q = gmul(x, x);
    r = q;
    for (int k = 1; k < 7; k++) begin
      q = gmul(q, q);
      r = gmul(r, q);
    end
    return r;
  endfunction
  logic [7:0] b;
  assign b = ginv(a);
  assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128/192/256 key schedule streaming round keys with backpressure
module aes_key_expand
  import aes_key_pkg::*;
#(
  parameter int MAX_KEY_W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [255:0] key_i,
  input  logic [1:0]   key_len_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_last_o,
  output logic         err_o
);
  state_t state, state_n;
  logic [7:0][31:0] key_r, win;
  logic [95:0] col;
  logic [5:0] i, nw;
  logic [3:0] nk;
  logic [2:0] m;
  logic [7:0] rcon, rcon_next;
  logic [31:0] w, f;
  logic accept, illegal, out_free, adv, key_phase, rot, sub;
  assign key_ready_o = state == IDLE;
  assign accept = key_valid_i && key_ready_o;
  assign illegal = key_len_i == LEN_RSV || key_bits_of(key_len_i) > MAX_KEY_W;
  assign out_free = !rk_valid_o || rk_ready_i;
  // only the word completing a round key can be blocked by a held output register
  assign adv = state == RUN && (i[1:0] != 2'd3 || out_free);
  assign key_phase = i < 6'(nk);
  assign rot = !key_phase && m == 3'd0;
  assign sub = !key_phase && nk == 4'd8 && m == 3'd4;
  assign w = key_phase ? key_r[i[2:0]] : win[3'(nk - 4'd1)] ^ f;
  aes_key_word_fn u_fn (.word(win[0]), .rcon(rcon), .rot(rot), .sub(sub), .f(f), .rcon_next(rcon_next));
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept && !illegal ? RUN : IDLE)
            : state == RUN ? (adv && i == nw - 6'd1 ? DONE : RUN)
            : (rk_valid_o && rk_ready_i && rk_last_o ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid_o <= 1'b0;
      rk_o <= '0;
      rk_idx_o <= '0;
      rk_last_o <= 1'b0;
      err_o <= 1'b0;
      key_r <= '0;
      win <= '0;
      col <= '0;
      i <= '0;
      m <= '0;
      nk <= 4'd4;
      nw <= 6'd44;
      rcon <= RCON_INIT;
    end else begin
      err_o <= accept && illegal;
      if (accept && !illegal) begin
        key_r <= key_i;
        nk <= nk_of(key_len_i);
        nw <= words_of(key_len_i);
        i <= '0;
        m <= '0;
        rcon <= RCON_INIT;
      end
      if (adv) begin
        i <= i + 6'd1;
        m <= m == 3'(nk - 4'd1) ? 3'd0 : m + 3'd1;
        win <= {win[6:0], w};
        col <= {w, col[95:32]};
        if (rot) rcon <= rcon_next;
      end
      if (adv && i[1:0] == 2'd3) begin
        rk_valid_o <= 1'b1;
        rk_o <= {w, col};
        rk_idx_o <= i[5:2];
        rk_last_o <= i == nw - 6'd1;
      end else if (rk_ready_i) rk_valid_o <= 1'b0;
    end
  end
endmodule
